// File: rtl/pc_stack.sv
// Program counter with a LIFO return-address stack (call/ret) and sticky overflow/underflow flags.
// One-cycle latency on all registered outputs; full/empty are decoded combinationally from depth.
module pc_stack #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic                       load,
  input  logic                       call,
  input  logic                       ret,
  input  logic                       clr,
  input  logic                       err_clr,
  input  logic [DATA_W-1:0]          data_in,
  output logic [ADDR_W-1:0]          data_out,
  output logic [$clog2(DEPTH+1)-1:0] depth,
  output logic                       full,
  output logic                       empty,
  output logic                       ovf,
  output logic                       unf
);

  localparam int DW = $clog2(DEPTH+1);
  localparam int IW = $clog2(DEPTH);
  localparam logic [DW-1:0]     ONE_D = 1;
  localparam logic [ADDR_W-1:0] ONE_A = 1;

  logic [ADDR_W-1:0] r_pc;
  logic [DW-1:0]     r_depth;
  logic              r_ovf;
  logic              r_unf;
  logic [ADDR_W-1:0] r_stack [DEPTH];

  logic [ADDR_W-1:0] w_target;
  logic [ADDR_W-1:0] w_pc_inc;
  logic [DW-1:0]     w_depth_m1;
  logic [IW-1:0]     w_wr_idx;
  logic [IW-1:0]     w_rd_idx;
  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_unused_hi;

  assign w_target    = data_in[ADDR_W-1:0];
  assign w_unused_hi = ^data_in;
  assign w_pc_inc    = r_pc + ONE_A;
  assign w_depth_m1  = r_depth - ONE_D;
  assign w_wr_idx    = r_depth[IW-1:0];
  assign w_rd_idx    = w_depth_m1[IW-1:0];
  assign w_full      = (r_depth == DW'(DEPTH));
  assign w_empty     = (r_depth == '0);
  // Push only on a call that wins priority and has room; an overflowing call still jumps.
  assign w_push      = en & ~load & call & ~w_full;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc    <= '0;
      r_depth <= '0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else begin
      if (en) begin
        if (load) begin
          r_pc <= w_target;
        end else if (call) begin
          r_pc <= w_target;
          if (w_full) r_ovf   <= 1'b1;
          else        r_depth <= r_depth + ONE_D;
        end else if (ret) begin
          if (w_empty) begin
            r_pc  <= w_pc_inc;
            r_unf <= 1'b1;
          end else begin
            r_pc    <= r_stack[w_rd_idx];
            r_depth <= w_depth_m1;
          end
        end else if (clr) begin
          r_pc <= '0;
        end else begin
          r_pc <= w_pc_inc;
        end
      end
      // Placed last so a same-cycle clear beats a same-cycle error.
      if (err_clr) begin
        r_ovf <= 1'b0;
        r_unf <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_stack[w_wr_idx] <= w_pc_inc;
  end

  assign data_out = r_pc;
  assign depth    = r_depth;
  assign full     = w_full;
  assign empty    = w_empty;
  assign ovf      = r_ovf;
  assign unf      = r_unf;

endmodule

// File: tb/tb_pc_stack.sv
// Directed bench for pc_stack at default parameters (ADDR_W=15, DATA_W=16, DEPTH=8).
module tb_pc_stack;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0, load = 1'b0, call = 1'b0, ret = 1'b0, clr = 1'b0, err_clr = 1'b0;
  logic [15:0] data_in = '0;
  logic [14:0] data_out;
  logic [3:0]  depth;
  logic        full, empty, ovf, unf;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] ret_addr [9];

  pc_stack #(.ADDR_W(15), .DATA_W(16), .DEPTH(8)) dut (
    .clk(clk), .rst(rst), .en(en), .load(load), .call(call), .ret(ret), .clr(clr),
    .err_clr(err_clr), .data_in(data_in), .data_out(data_out), .depth(depth),
    .full(full), .empty(empty), .ovf(ovf), .unf(unf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drv(input logic e, input logic l, input logic c, input logic r,
                     input logic cl, input logic ec, input logic [15:0] d);
    en = e; load = l; call = c; ret = r; clr = cl; err_clr = ec; data_in = d;
    @(posedge clk);
    #1;
  endtask

  task automatic st(input string tag, input logic [31:0] pc, input logic [31:0] dp);
    chk({tag, ".pc"}, 32'(data_out), pc);
    chk({tag, ".depth"}, 32'(depth), dp);
  endtask

  initial begin
    #12;
    st("reset", 'h0, 0);
    chk("reset.empty", 32'(empty), 1);
    chk("reset.full", 32'(full), 0);
    chk("reset.ovf", 32'(ovf), 0);
    chk("reset.unf", 32'(unf), 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    st("hold_no_en", 'h0, 0);

    // Free-running increment after reset
    for (int i = 1; i <= 3; i++) begin
      drv(1, 0, 0, 0, 0, 0, 'h0);
      st("inc", 32'(i), 0);
      chk("inc.empty", 32'(empty), 1);
    end

    // Wrap at top of address space, upper data bit ignored
    drv(1, 1, 0, 0, 0, 0, 'hFFFF);
    st("load_max", 'h7FFF, 0);
    drv(1, 0, 0, 0, 0, 0, 'h0);
    st("wrap", 'h0, 0);
    chk("wrap.ovf", 32'(ovf), 0);
    chk("wrap.unf", 32'(unf), 0);

    // Single call / return
    drv(1, 1, 0, 0, 0, 0, 'h0010);
    drv(1, 0, 1, 0, 0, 0, 'h0100);
    st("call1", 'h0100, 1);
    chk("call1.empty", 32'(empty), 0);
    for (int i = 0; i < 4; i++) drv(1, 0, 0, 0, 0, 0, 'h0);
    st("call1.inc4", 'h0104, 1);
    drv(1, 0, 0, 1, 0, 0, 'h0);
    st("ret1", 'h0011, 0);

    // DEPTH+1 calls: last push dropped, ovf set, jump still taken
    drv(1, 1, 0, 0, 0, 0, 'h1000);
    ret_addr[0] = 'h1001;
    for (int i = 0; i < 9; i++) begin
      drv(1, 0, 1, 0, 0, 0, 16'('h2000 + i * 'h100));
      ret_addr[i+1] = 32'('h2000 + i * 'h100 + 1);
      if (i == 7) begin
        chk("call8.full", 32'(full), 1);
        chk("call8.ovf", 32'(ovf), 0);
      end
    end
    st("call9", 'h2800, 8);
    chk("call9.full", 32'(full), 1);
    chk("call9.ovf", 32'(ovf), 1);
    for (int i = 7; i >= 0; i--) begin
      drv(1, 0, 0, 1, 0, 0, 'h0);
      st("ret_chain", ret_addr[i], 32'(i));
    end
    chk("ret_chain.empty", 32'(empty), 1);
    chk("ret_chain.ovf", 32'(ovf), 1);
    drv(0, 0, 0, 0, 0, 1, 'h0);
    chk("errclr.ovf", 32'(ovf), 0);
    st("errclr_hold", 'h1001, 0);

    // Underflow, clear, stall
    drv(1, 1, 0, 0, 0, 0, 'h0020);
    drv(1, 0, 0, 1, 0, 0, 'h0);
    st("unf_ret", 'h0021, 0);
    chk("unf_ret.unf", 32'(unf), 1);
    drv(0, 0, 0, 0, 0, 1, 'h0);
    chk("unf_clr.unf", 32'(unf), 0);
    drv(0, 1, 0, 0, 0, 0, 'h5555);
    st("stall_load", 'h0021, 0);
    drv(1, 0, 0, 1, 0, 1, 'h0);
    st("unf_vs_clr", 'h0022, 0);
    chk("unf_vs_clr.unf", 32'(unf), 0);

    // Priority: load > call > ret > clr
    drv(1, 1, 0, 0, 0, 0, 'h0033);
    drv(1, 0, 1, 0, 0, 0, 'h0040);
    st("pri_call", 'h0040, 1);
    drv(1, 1, 1, 0, 0, 0, 'h0050);
    st("pri_load_call", 'h0050, 1);
    drv(1, 0, 1, 1, 0, 0, 'h0060);
    st("pri_call_ret", 'h0060, 2);
    drv(1, 0, 0, 0, 1, 0, 'h0);
    st("clr", 'h0, 2);
    drv(1, 0, 0, 1, 1, 0, 'h0);
    st("pri_ret_clr", 'h0051, 1);
    drv(0, 0, 1, 0, 0, 0, 'h0070);
    st("stall_call", 'h0051, 1);
    drv(1, 0, 0, 1, 0, 0, 'h0);
    st("ret_after_stall", 'h0034, 0);

    // Build depth=3 with ovf=1, then async reset between edges
    for (int i = 0; i < 9; i++) drv(1, 0, 1, 0, 0, 0, 'h0100);
    for (int i = 0; i < 5; i++) drv(1, 0, 0, 1, 0, 0, 'h0);
    st("pre_rst", 'h0101, 3);
    chk("pre_rst.ovf", 32'(ovf), 1);
    drv(0, 0, 0, 0, 0, 0, 'h0);
    #2;
    rst = 1'b1;
    #1;
    st("async_rst", 'h0, 0);
    chk("async_rst.ovf", 32'(ovf), 0);
    @(negedge clk);
    rst = 1'b0;
    drv(1, 0, 0, 0, 0, 0, 'h0);
    st("post_rst", 'h1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pc_stack.md
PC_STACK -- requirements
Module: pc_stack

Interface
REQ-001 Parameter ADDR_W, default 15, PC width in bits.
REQ-002 Parameter DATA_W, default 16, data_in width in bits; SHALL be >= ADDR_W.
REQ-003 Parameter DEPTH, default 8, return-address stack entries; SHALL be >= 2.
REQ-004 clk  input  1  single clock; all state changes on the rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 en  input  1  advance enable; low = stall, PC and stack hold.
REQ-007 load  input  1  jump: PC <= data_in[ADDR_W-1:0].
REQ-008 call  input  1  jump and push the return address.
REQ-009 ret  input  1  pop the stack into PC.
REQ-010 clr  input  1  synchronous clear of PC to 0.
REQ-011 data_in  input  DATA_W  jump target; upper bits are ignored.
REQ-012 data_out  output  ADDR_W  current PC.
REQ-013 depth  output  $clog2(DEPTH+1)  number of valid stack entries.
REQ-014 full / empty  output  1 each  depth==DEPTH / depth==0, combinational from depth.
REQ-015 ovf / unf  output  1 each  sticky overflow / underflow error flags.
REQ-016 err_clr  input  1  synchronous clear of ovf and unf.

Function
REQ-017 With en=1, exactly one action SHALL occur per cycle, chosen in priority order load > call > ret > clr > increment.
REQ-018 Increment: data_out <= data_out+1 modulo 2^ADDR_W; 2^ADDR_W-1 SHALL wrap to 0 with no flag.
REQ-019 Load: data_out <= data_in[ADDR_W-1:0]; the stack is unchanged.
REQ-020 Call with full=0: push (data_out+1) mod 2^ADDR_W, depth+1, data_out <= data_in[ADDR_W-1:0].
REQ-021 Call with full=1: the jump SHALL still occur; the push is dropped, depth holds, ovf <= 1.
REQ-022 Ret with empty=0: data_out <= top entry, depth-1.
REQ-023 Ret with empty=1: treat as increment; depth stays 0, unf <= 1.
REQ-024 Clr: data_out <= 0; the stack and depth are unchanged.
REQ-025 With en=0: data_out, depth and stack contents SHALL hold regardless of load/call/ret/clr; err_clr is still honoured.
REQ-026 err_clr=1 SHALL clear ovf/unf that cycle, and SHALL win over a same-cycle set.
REQ-027 Stack SHALL be LIFO; the top entry is the most recent successful push; entries at or above depth are don't-care.
REQ-028 All outputs are registered except full and empty; new values are visible the cycle after the edge (latency 1).

Reset
REQ-029 While rst=1, asynchronously: data_out=0, depth=0, ovf=0, unf=0; stack contents need not be cleared.
REQ-030 After rst deasserts, the first rising edge SHALL act per REQ-017 (with en=1 and no controls, data_out=1).

Verification
REQ-031 Reset, then en=1 for 3 cycles with no controls -> data_out 0,1,2,3; depth=0; empty=1.
REQ-032 load with data_in=0xFFFF (ADDR_W=15) -> data_out=0x7FFF; next increment -> 0x0000, no flags.
REQ-033 data_out=0x0010, call data_in=0x0100 -> data_out=0x0100, depth=1; 4 increments, then ret -> data_out=0x0011, depth=0.
REQ-034 DEPTH+1 consecutive calls -> depth=DEPTH, full=1, ovf=1, final PC = last target; DEPTH rets then return the first DEPTH return addresses in reverse order.
REQ-035 ret with empty=1 at data_out=0x0020 -> data_out=0x0021, unf=1; err_clr -> unf=0; then en=0 plus load -> PC holds 0x0021.
REQ-036 rst asserted mid-cycle with depth=3 and ovf=1 -> immediately data_out=0, depth=0, ovf=0 without waiting for a clock edge.
